// File: rtl/gcd_stein_unit.sv
`default_nettype none
// ============================================================================
// Module  : gcd_stein_unit
// Brief   : Iterative binary (Stein) GCD with iteration count and zero flag.
// Revision: 1.0
// ============================================================================
module gcd_stein_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd,
    output logic             zero_err,
    output logic [CNT_W-1:0] iters
);

    localparam int SH_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [SH_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_gcd;
    logic             r_zero_err;
    logic [CNT_W-1:0] r_iters;

    logic             w_ra_zero;
    logic             w_rb_zero;
    logic             w_ra_even;
    logic             w_rb_even;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_diff_ab;
    logic [WIDTH-1:0] w_diff_ba;
    logic [WIDTH-1:0] w_base;

    assign w_ra_zero = (r_ra == '0);
    assign w_rb_zero = (r_rb == '0);
    assign w_ra_even = ~r_ra[0];
    assign w_rb_even = ~r_rb[0];
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_diff_ab = r_ra - r_rb;
    assign w_diff_ba = r_rb - r_ra;
    // The surviving operand: rb when ra has reached zero, otherwise ra.
    assign w_base    = w_ra_zero ? r_rb : r_ra;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ra       <= '0;
            r_rb       <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_gcd      <= '0;
            r_zero_err <= 1'b0;
            r_iters    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ra    <= a;
                        r_rb    <= b;
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_cnt <= w_cnt_inc;
                    if (w_ra_zero && w_rb_zero) begin
                        r_gcd      <= '0;
                        r_zero_err <= 1'b1;
                        r_iters    <= w_cnt_inc;
                        r_state    <= S_FINISH;
                    end else if (w_ra_zero || w_rb_zero || (r_ra == r_rb)) begin
                        r_gcd      <= w_base << r_shift;
                        r_zero_err <= 1'b0;
                        r_iters    <= w_cnt_inc;
                        r_state    <= S_FINISH;
                    end else if (w_ra_even && w_rb_even) begin
                        r_ra    <= r_ra >> 1;
                        r_rb    <= r_rb >> 1;
                        r_shift <= r_shift + SH_W'(1);
                    end else if (w_ra_even) begin
                        r_ra <= r_ra >> 1;
                    end else if (w_rb_even) begin
                        r_rb <= r_rb >> 1;
                    end else if (r_ra > r_rb) begin
                        r_ra <= w_diff_ab >> 1;
                    end else begin
                        r_rb <= w_diff_ba >> 1;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = (r_state == S_CALC) || (r_state == S_FINISH);
    assign done     = (r_state == S_FINISH);
    assign gcd      = r_gcd;
    assign zero_err = r_zero_err;
    assign iters    = r_iters;

endmodule
`default_nettype wire

// File: tb/tb_gcd_stein_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_gcd_stein_unit
// Brief   : Directed self-checking bench for gcd_stein_unit (16- and 32-bit).
// Revision: 1.0
// ============================================================================
module tb_gcd_stein_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] gcd;
    logic        zero_err;
    logic [7:0]  iters;

    logic        start32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        busy32;
    logic        done32;
    logic [31:0] gcd32;
    logic        zero_err32;
    logic [7:0]  iters32;

    int n_checks = 0;
    int n_errors = 0;

    gcd_stein_unit #(.WIDTH(16), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .gcd(gcd), .zero_err(zero_err), .iters(iters)
    );

    gcd_stein_unit #(.WIDTH(32), .CNT_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .gcd(gcd32), .zero_err(zero_err32), .iters(iters32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses start with the given operands and checks the whole transaction.
    task automatic do_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic [15:0] exp_gcd, input logic exp_zero, input logic [7:0] exp_iters);
        int n;
        int busy_cycles;
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        busy_cycles = 0;
        while (!done && n < 300) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            n++;
        end
        if (busy) busy_cycles++;
        check_val({tag, "_done"},     64'(done),     64'd1);
        check_val({tag, "_gcd"},      64'(gcd),      64'(exp_gcd));
        check_val({tag, "_zero_err"}, 64'(zero_err), 64'(exp_zero));
        check_val({tag, "_iters"},    64'(iters),    64'(exp_iters));
        check_val({tag, "_latency"},  64'(n),        64'(exp_iters) + 64'd1);
        check_val({tag, "_busy_cyc"}, 64'(busy_cycles), 64'(exp_iters) + 64'd1);
        @(posedge clk); #1;
        check_val({tag, "_done_off"}, 64'(done), 64'd0);
        check_val({tag, "_busy_off"}, 64'(busy), 64'd0);
        check_val({tag, "_gcd_hold"}, 64'(gcd),  64'(exp_gcd));
    endtask

    initial begin
        int n;
        int done_seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start32 = 1'b0; a32 = '0; b32 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy",     64'(busy),     64'd0);
        check_val("rst_done",     64'(done),     64'd0);
        check_val("rst_gcd",      64'(gcd),      64'd0);
        check_val("rst_zero_err", 64'(zero_err), 64'd0);
        check_val("rst_iters",    64'(iters),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("idle_busy", 64'(busy), 64'd0);
        end

        do_op("g9_3",   16'd9,  16'd3,  16'd3, 1'b0, 8'd2);
        do_op("g48_18", 16'd48, 16'd18, 16'd6, 1'b0, 8'd6);
        do_op("g0_7",   16'd0,  16'd7,  16'd7, 1'b0, 8'd1);
        do_op("g0_0",   16'd0,  16'd0,  16'd0, 1'b1, 8'd1);
        do_op("g5_2",   16'd5,  16'd2,  16'd1, 1'b0, 8'd4);

        // start held high; operand change while busy must not disturb 9,3.
        @(negedge clk);
        a = 16'd9; b = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        a = 16'd5; b = 16'd2;
        n = 1;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("bb1_done", 64'(done), 64'd1);
        check_val("bb1_gcd",  64'(gcd),  64'd3);
        check_val("bb1_lat",  64'(n),    64'd3);
        @(posedge clk); #1;
        check_val("bb_idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check_val("bb2_accept", 64'(busy), 64'd1);
        n = 1;
        while (!done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check_val("bb2_done",  64'(done),  64'd1);
        check_val("bb2_gcd",   64'(gcd),   64'd1);
        check_val("bb2_iters", 64'(iters), 64'd4);
        @(posedge clk); #1;

        // Abort in CALC: reset wins and no done follows.
        @(negedge clk);
        a = 16'd48; b = 16'd18; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("abort_busy",  64'(busy),     64'd0);
        check_val("abort_gcd",   64'(gcd),      64'd0);
        check_val("abort_iters", 64'(iters),    64'd0);
        check_val("abort_zero",  64'(zero_err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check_val("abort_no_done", 64'(done_seen), 64'd0);

        // 32-bit instance: gcd(2^31, 2^30) = 2^30 after 30 halvings + 2 cycles.
        @(negedge clk);
        a32 = 32'h8000_0000; b32 = 32'h4000_0000; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        n = 1;
        while (!done32 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("w32_done",  64'(done32),     64'd1);
        check_val("w32_gcd",   64'(gcd32),      64'h4000_0000);
        check_val("w32_zero",  64'(zero_err32), 64'd0);
        check_val("w32_iters", 64'(iters32),    64'd32);
        check_val("w32_lat",   64'(n),          64'd33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gcd_stein_unit.md
GCD_STEIN_UNIT -- requirements
Module: gcd_stein_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; legal 4..64.
REQ-002 Parameter CNT_W, default 8: width of the iteration counter output.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high, sampled on rising clk.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  WIDTH  operand A, unsigned; captured on the accepting edge.
REQ-007 b  input  WIDTH  operand B, unsigned; captured on the accepting edge.
REQ-008 busy  output  1  high in CALC and FINISH.
REQ-009 done  output  1  one-cycle pulse, high only in FINISH.
REQ-010 gcd  output  WIDTH  result; registered; held until the next accepted start.
REQ-011 zero_err  output  1  high with the result when both operands are 0; held like gcd.
REQ-012 iters  output  CNT_W  number of CALC cycles used by the last operation, including the terminal cycle; held like gcd.

Function
REQ-013 The FSM SHALL have exactly 3 states: IDLE, CALC and FINISH; all outputs SHALL be registered or decoded from the state only.
REQ-014 In IDLE with start=1, the edge SHALL load internal regs ra=a, rb=b, shift=0, cnt=0 and go to CALC; gcd, zero_err and iters are unchanged at this edge.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-016 Each CALC edge SHALL increment cnt, saturating at all-ones, and apply the first matching rule of REQ-017 to REQ-022.
REQ-017 If ra=0 and rb=0: gcd=0, zero_err=1, go to FINISH.
REQ-018 If ra=0 or rb=0 or ra=rb: gcd=(nonzero operand, or ra)<<shift, zero_err=0, go to FINISH.
REQ-019 If ra and rb are both even: ra>>=1, rb>>=1, shift+=1.
REQ-020 If only ra is even: ra>>=1; if only rb is even: rb>>=1.
REQ-021 If both are odd and ra>rb: ra=(ra-rb)>>1.
REQ-022 If both are odd and ra<rb: rb=(rb-ra)>>1.
REQ-023 On the terminal edge (REQ-017/REQ-018), iters SHALL be set to cnt+1 (saturating).
REQ-024 Subtraction SHALL be WIDTH-bit and shift a log2(WIDTH)+1-bit counter; the result SHALL never overflow because gcd<=max(a,b).
REQ-025 The FINISH state SHALL last exactly one cycle and then go unconditionally to IDLE; done=1 only during FINISH.
REQ-026 start SHALL be ignored in CALC and FINISH; operand changes during busy SHALL have no effect.
REQ-027 start held high continuously SHALL be accepted on the first IDLE cycle after FINISH, giving back-to-back operations with one IDLE cycle between.
REQ-028 Latency from the accepting edge to done high SHALL be iters+1 edges.

Reset
REQ-029 With rst=1 at an edge: state=IDLE, busy=0, done=0, gcd=0, zero_err=0, iters=0, internal regs=0.
REQ-030 rst SHALL override start and any in-flight CALC/FINISH; no done pulse SHALL follow an aborted operation.

Verification
REQ-031 Assert rst for 2 cycles -> all outputs 0, busy=0; start=0 for 5 cycles -> the block stays in IDLE.
REQ-032 a=9, b=3, start pulse -> iters=2, gcd=3, done high on the 3rd edge after acceptance for exactly 1 cycle, busy high for 3 cycles.
REQ-033 a=48, b=18 -> gcd=6, iters=6, zero_err=0; then a=0, b=7 -> gcd=7, iters=1.
REQ-034 a=0, b=0 -> gcd=0, zero_err=1, iters=1; next a=5, b=2 -> gcd=1, zero_err cleared.
REQ-035 a=9, b=3 accepted, then a=5, b=2 with start=1 while busy -> result 3, no second acceptance until IDLE; start still high -> 5,2 processed next, gcd=1.
REQ-036 Assert rst during CALC of a=48, b=18 -> next cycle busy=0, gcd=0, no done; WIDTH=32, a=2^31, b=2^30 -> gcd=2^30.
